trace_array_muxin: RTL
======================

TRACE_ARRAY_MUXIN -- requirements
Module: trace_array_muxin

Interface
REQ-001 Parameter DATA_OUT_WIDTH, default 256, width of the assembled trace vector; SHALL be a multiple of 64, minimum 128.
REQ-002 Parameter LOOP_NUM, default DATA_OUT_WIDTH/64, number of 64-bit slots.
REQ-003 Parameter SEL_WIDTH, default $clog2(LOOP_NUM), slot index width.
REQ-004 ha_pclock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a word this cycle.
REQ-007 in_data  input  [0:63]  trace word.
REQ-008 in_last  input  1  qualifies the accepted word as the final word of a partial vector.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 out_valid  output  1  out_data/out_words hold a complete vector.
REQ-011 out_data  output  [0:DATA_OUT_WIDTH-1]  assembled vector; slot i occupies bits i*64 to i*64+63.
REQ-012 out_words  output  [0:SEL_WIDTH]  number of filled slots, range 1..LOOP_NUM.
REQ-013 out_ready  input  1  consumer takes the vector this cycle.

Function
REQ-014 A word SHALL be accepted when in_valid and in_ready are both 1 on a rising edge; there are no other acceptance conditions.
REQ-015 Slot counter slot (SEL_WIDTH bits) SHALL select the destination slot; accepted word written to bits slot*64..slot*64+63; the first word after reset or drain goes to slot 0.
REQ-016 FSM states: FILL, HOLD.
REQ-017 FILL: in_ready=1, out_valid=0; accept with slot<LOOP_NUM-1 and in_last=0 -> slot+1, stay in FILL.
REQ-018 FILL: accept with slot==LOOP_NUM-1, or with in_last=1 -> HOLD next cycle with out_valid=1 and out_words=slot+1 (one-cycle latency from final accept to out_valid).
REQ-019 Slots not written since the last drain SHALL read as zero in out_data.
REQ-020 HOLD: out_data and out_words stable; in_ready SHALL equal out_ready (combinational).
REQ-021 HOLD with out_ready=1 and no accept -> FILL, buffer cleared to zero, slot=0.
REQ-022 HOLD with out_ready=1 and simultaneous accept -> buffer cleared, the new word written to slot 0; next state per REQ-017/018 evaluated with slot=0 (in_last=1 or LOOP_NUM==1 -> HOLD with out_words=1); otherwise FILL with slot=1.
REQ-023 HOLD with out_ready=0: no accept, no state change; in_data ignored.
REQ-024 out_ready while in FILL SHALL be ignored.
REQ-025 in_last while in_valid=0 SHALL be ignored.
REQ-026 Throughput: one word per cycle sustained when out_ready=1 throughout; no bubble at vector boundaries.

Reset
REQ-027 Reset SHALL force state FILL, slot=0, buffer all zero, out_valid=0, out_words=0, in_ready=1 (once reset deasserts).
REQ-028 in_ready SHALL be 0 while reset is asserted.
REQ-029 Reset asserted mid-fill or in HOLD SHALL discard the partial/held vector with no output.

Structure
REQ-030 Shared package trace_array_pkg SHALL hold TRACE_WORD_WIDTH=64 and the FSM state encoding; also used by trace array mux-out logic.
REQ-031 Single flat module; no sub-module; slot write decode inline with a generate loop over LOOP_NUM.

Verification
REQ-032 Default params, out_ready=1, words 0x1..0x4 back-to-back -> out_valid one cycle after 4th, out_data=0x..01|..02|..03|..04 (slot0 msb side), out_words=4.
REQ-033 Words 0xA, 0xB with in_last on 0xB -> out_data slots {0xA,0xB,0,0}, out_words=2.
REQ-034 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_data unchanged, no word lost; release -> the pending word lands in slot 0 of next vector.
REQ-035 Continuous 8 words, out_ready=1 -> two vectors, in_ready never 0, second vector = words 5..8.
REQ-036 Reset pulse after 2 accepted words -> out_valid=0, next 4 words form a vector starting at slot 0 with no stale data.
REQ-037 Single word with in_last, out_ready=1 same cycle as drain of prior vector -> out_words=1, slots 1..3 zero.

Source files
------------

// File: rtl/trace_array_pkg.sv
// Definitions shared by the trace array mux-in and mux-out logic:
// trace word width and the FILL/HOLD state encoding.
package trace_array_pkg;

  localparam int TRACE_WORD_WIDTH = 64;

  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_FILL = 1'b0;
  localparam logic [STATE_W-1:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/trace_array_muxin.sv
// Packs a stream of 64-bit trace words into a wide vector, slot 0 on the msb side,
// and holds the vector until the consumer takes it.
//
//   state | meaning
//   FILL  | accepting words into slot_q; out_valid low
//   HOLD  | vector complete; in_ready follows out_ready so a drain can overlap a new word
module trace_array_muxin
  import trace_array_pkg::*;
#(
  parameter int DATA_OUT_WIDTH = 256,
  parameter int LOOP_NUM       = DATA_OUT_WIDTH / TRACE_WORD_WIDTH,
  parameter int SEL_WIDTH      = $clog2(LOOP_NUM)
) (
  input  logic                      ha_pclock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [0:63]               in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [0:DATA_OUT_WIDTH-1] out_data,
  output logic [0:SEL_WIDTH]        out_words,
  input  logic                      out_ready
);

  localparam logic [SEL_WIDTH-1:0] LAST_SLOT = SEL_WIDTH'(LOOP_NUM - 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [SEL_WIDTH-1:0] slot_q, slot_d;
  logic [0:SEL_WIDTH]   words_q, words_d;

  logic                 accept;
  logic                 clear;
  logic                 wr_en;
  logic [SEL_WIDTH-1:0] wr_slot;

  assign in_ready  = !reset && ((state_q == ST_FILL) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign out_words = words_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    words_d = words_q;
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = slot_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if ((slot_q == LAST_SLOT) || in_last) begin
            state_d = ST_HOLD;
            words_d = (SEL_WIDTH+1)'(slot_q) + (SEL_WIDTH+1)'(1);
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SEL_WIDTH'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          // Drain clears the buffer; a word taken on the same edge becomes slot 0.
          clear   = 1'b1;
          state_d = ST_FILL;
          slot_d  = '0;
          words_d = '0;
          if (accept) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            if (in_last || (LOOP_NUM == 1)) begin
              state_d = ST_HOLD;
              words_d = (SEL_WIDTH+1)'(1);
            end else begin
              slot_d = SEL_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_FILL;
        slot_d  = '0;
        words_d = '0;
      end
    endcase
  end

  always_ff @(posedge ha_pclock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      slot_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      words_q <= words_d;
    end
  end

  for (genvar g = 0; g < LOOP_NUM; g++) begin : g_slot
    logic [0:TRACE_WORD_WIDTH-1] word_q, word_d;

    always_comb begin
      word_d = word_q;
      if (clear) word_d = '0;
      if (wr_en && (wr_slot == SEL_WIDTH'(g))) word_d = in_data;
    end

    always_ff @(posedge ha_pclock or posedge reset) begin
      if (reset) word_q <= '0;
      else       word_q <= word_d;
    end

    assign out_data[g*TRACE_WORD_WIDTH +: TRACE_WORD_WIDTH] = word_q;
  end

endmodule
